// File: rtl/spike_dec_pkg.sv
// Shared definitions for the spike rate decoder: FSM states, window
// length constants and the helper that turns a window_len code into a
// cycle-counter load value.
package spike_dec_pkg;

  // Decoder FSM states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  // Width of the window_len input.
  localparam int WIN_LEN_W = 8;

  // The cycle counter must hold 256, so it is one bit wider than window_len.
  localparam int CYC_W = WIN_LEN_W + 1;

  // Window length used when window_len is programmed as zero.
  localparam logic [CYC_W-1:0] ZERO_LEN_WINDOW = 9'd256;

  // Default per-channel count width.
  localparam int CNT_W_DEFAULT = 8;

  // Convert a window_len code into the cycle-counter load value (0 -> 256).
  function automatic logic [CYC_W-1:0] window_load(input logic [WIN_LEN_W-1:0] len);
    logic [CYC_W-1:0] v;
    if (len == 8'd0) begin
      v = ZERO_LEN_WINDOW;
    end else begin
      v = {1'b0, len};
    end
    return v;
  endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// One channel of the decoder: rising-edge detection on a level spike flag
// and a saturating event counter with synchronous clear.
// o_count_next is the value the counter takes on the coming edge if not
// cleared, so the closing cycle's edge can be folded into a finished result.
module spike_edge_counter
  import spike_dec_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_spike,
  input  logic             i_count_en,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count_next
);

  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_sat;
  logic [CNT_W-1:0] w_count_next;

  assign w_rise       = i_spike & ~r_prev;
  assign w_sat        = &r_count;
  assign o_count_next = w_count_next;

  // Next count: increment on a counted rising edge unless already saturated.
  always_comb begin
    w_count_next = r_count;
    if (i_count_en && w_rise && !w_sat) begin
      w_count_next = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_count_next = r_count;
    end
  end

  // Edge history tracks the input every cycle, whether or not counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_spike;
    end
  end

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges on NUM_CH spike inputs over
// back-to-back windows of window_len cycles and hands each window's counts
// to a single-entry valid/ready output register. A result offered while
// the previous one is still unconsumed is dropped and flagged in overrun.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [WIN_LEN_W-1:0]    window_len,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [NUM_CH*CNT_W-1:0] out_counts,
  output logic                    busy,
  output logic                    overrun
);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [CYC_W-1:0]        r_cyc;
  logic [CYC_W-1:0]        w_cyc_next;
  logic                    w_offer;
  logic                    w_clear;
  logic                    w_count_en;
  logic                    w_xfer;
  logic                    w_load;
  logic                    w_valid_next;
  logic                    w_overrun_next;
  logic [NUM_CH*CNT_W-1:0] w_counts_next;
  logic                    r_out_valid;
  logic [NUM_CH*CNT_W-1:0] r_out_counts;
  logic                    r_busy;
  logic                    r_overrun;

  assign out_valid  = r_out_valid;
  assign out_counts = r_out_counts;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

  // A transfer happens whenever a held result meets a ready consumer.
  assign w_xfer = r_out_valid & out_ready;

  // Per-channel edge counters share one clear and one count enable.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_edge_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .i_spike      (spike_in[g]),
      .i_count_en   (w_count_en),
      .i_clear      (w_clear),
      .o_count_next (w_counts_next[g*CNT_W +: CNT_W])
    );
  end

  // FSM state and cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cyc   <= 9'd0;
    end else begin
      r_state <= w_state_next;
      r_cyc   <= w_cyc_next;
    end
  end

  // FSM next state: window start, countdown, closing offer and abort.
  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_offer      = 1'b0;
    w_clear      = 1'b0;
    w_count_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          // Start a window: latch the length and wipe the counters.
          w_state_next = ST_COUNT;
          w_cyc_next   = window_load(window_len);
          w_clear      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_cyc_next   = 9'd0;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          // Abort: partial counts are thrown away, no result produced.
          w_state_next = ST_IDLE;
          w_cyc_next   = 9'd0;
          w_clear      = 1'b1;
        end else if (r_cyc == 9'd1) begin
          // Closing cycle: its edges still count, then the next window
          // starts immediately with a freshly latched length.
          w_state_next = ST_COUNT;
          w_count_en   = 1'b1;
          w_offer      = 1'b1;
          w_clear      = 1'b1;
          w_cyc_next   = window_load(window_len);
        end else begin
          w_state_next = ST_COUNT;
          w_count_en   = 1'b1;
          w_cyc_next   = r_cyc - 9'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cyc_next   = 9'd0;
        w_clear      = 1'b1;
      end
    endcase
  end

  // Output register control: load, drop-with-overrun, or drain on transfer.
  always_comb begin
    w_load         = 1'b0;
    w_valid_next   = r_out_valid;
    w_overrun_next = r_overrun;
    if (w_offer) begin
      if (!r_out_valid || w_xfer) begin
        w_load       = 1'b1;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end else if (w_xfer) begin
      w_valid_next = 1'b0;
    end else begin
      w_valid_next = r_out_valid;
    end
  end

  // Output registers; counts only change on a load so they stay stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_counts <= '0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_out_valid <= w_valid_next;
      r_overrun   <= w_overrun_next;
      r_busy      <= (w_state_next == ST_COUNT);
      if (w_load) begin
        r_out_counts <= w_counts_next;
      end else begin
        r_out_counts <= r_out_counts;
      end
    end
  end

endmodule
